fb_scanout: RTL

- Parametrised VGA scanout engine between VGA_controller and the VGA DAC pins; replaces the fixed frame-buffer-plus-palette path in the top level.
- Generates linear frame-buffer read addresses and reads palette indices from an external synchronous VRAM port.
- Maps indices through an internal writable palette, with multi-buffer page flipping under a swap handshake.
- Adds a built-in colour-bar test mode that needs no VRAM.

---
 rtl/fb_pkg.sv | 28 ++
 rtl/fb_palette_ram.sv | 25 ++
 rtl/fb_scanout.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/fb_pkg.sv
// Shared types and constants for the frame-buffer scanout engine.
package fb_pkg;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned COLOR_W_DEF  = 8;

  localparam int unsigned FRAME_PIX = H_ACTIVE_DEF * V_ACTIVE_DEF;
  localparam int unsigned PIPE_LAT  = 3;

  typedef struct packed {
    logic [COLOR_W_DEF-1:0] r;
    logic [COLOR_W_DEF-1:0] g;
    logic [COLOR_W_DEF-1:0] b;
  } rgb_t;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } swap_state_t;

  // VRAM base address of frame buffer 'b'; evaluated at elaboration only
  function automatic int unsigned buf_base(input int unsigned b,
                                           input int unsigned frame_pix);
    return b * frame_pix;
  endfunction

endpackage

// File: rtl/fb_palette_ram.sv
// Palette memory: one write port, one registered read port, old data on
// read-during-write to the same address.
module fb_palette_ram #(
  parameter int unsigned IDX_W  = 6,
  parameter int unsigned DATA_W = 24
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [IDX_W-1:0]  raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [0:(1<<IDX_W)-1];

  // Write and read share the edge; the NBA read returns the pre-write entry
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/fb_scanout.sv
// VGA scanout: linear VRAM addressing, palette lookup, page flipping and a
// colour-bar test mode. Fixed latency of 3 Clk from mem_addr to RGB.
module fb_scanout
  import fb_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned IDX_W    = 6,
  parameter int unsigned COLOR_W  = 8,
  parameter int unsigned NUM_BUFS = 2,
  parameter int unsigned ADDR_W   = 21
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 pix_en,
  input  logic                 active,
  input  logic                 frame_end,
  input  logic                 test_mode,
  input  logic                 swap_req,
  output logic                 swap_ack,
  output logic [1:0]           front_buf,
  output logic [ADDR_W-1:0]    mem_addr,
  input  logic [IDX_W-1:0]     mem_rdata,
  input  logic                 pal_we,
  input  logic [IDX_W-1:0]     pal_waddr,
  input  logic [3*COLOR_W-1:0] pal_wdata,
  output logic [COLOR_W-1:0]   vga_r,
  output logic [COLOR_W-1:0]   vga_g,
  output logic [COLOR_W-1:0]   vga_b
);

  localparam int unsigned PIX_PER_FRAME = H_ACTIVE * V_ACTIVE;
  localparam int unsigned CNT_W         = $clog2(PIX_PER_FRAME);
  localparam int unsigned BAR_PIX       = H_ACTIVE / 8;
  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(PIX_PER_FRAME - 1);

  localparam logic [ADDR_W-1:0] BASE1 = ADDR_W'(buf_base(1, PIX_PER_FRAME));
  localparam logic [ADDR_W-1:0] BASE2 = ADDR_W'(buf_base(2, PIX_PER_FRAME));
  localparam logic [ADDR_W-1:0] BASE3 = ADDR_W'(buf_base(3, PIX_PER_FRAME));

  swap_state_t          state_q;
  logic [1:0]           next_buf;
  logic [ADDR_W-1:0]    base_sel;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CNT_W-1:0]     cnt_s0_q;
  logic                 v0_q, v1_q, v2_q;
  logic [2:0]           bar_q, bar_s2_q;
  logic                 tm_s1_q, tm_s2_q;
  logic [3*COLOR_W-1:0] pal_rdata;

  // Next front buffer, wrapping at NUM_BUFS (stays 0 for a single buffer)
  always_comb begin
    next_buf = front_buf + 2'd1;
    if (front_buf >= 2'(NUM_BUFS - 1)) begin
      next_buf = '0;
    end
  end

  // Per-buffer base address as a constant mux, keeping multipliers off the pixel path
  always_comb begin
    base_sel = '0;
    case (front_buf)
      2'd1:    base_sel = BASE1;
      2'd2:    base_sel = BASE2;
      2'd3:    base_sel = BASE3;
      default: base_sel = '0;
    endcase
  end

  // Pixel counter: frame_end clears with priority, saturates at the last pixel
  always_comb begin
    cnt_d = cnt_q;
    if (frame_end) begin
      cnt_d = '0;
    end else if (pix_en && active && (cnt_q != LAST_PIX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Pixel pipeline S0..S2: address, VRAM data / bar index, palette read
  always_ff @(posedge Clk) begin
    if (Reset) begin
      mem_addr <= '0;
      cnt_s0_q <= '0;
      v0_q     <= 1'b0;
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      bar_q    <= '0;
      bar_s2_q <= '0;
      tm_s1_q  <= 1'b0;
      tm_s2_q  <= 1'b0;
    end else begin
      mem_addr <= base_sel + ADDR_W'(cnt_q);
      cnt_s0_q <= cnt_q;
      v0_q     <= active;
      // bar index shadows mem_rdata so both paths share the palette-stage timing;
      // low 3 bits equal x/BAR_PIX since a line holds exactly 8 bars
      bar_q    <= 3'(cnt_s0_q / CNT_W'(BAR_PIX));
      tm_s1_q  <= test_mode;
      v1_q     <= v0_q;
      bar_s2_q <= bar_q;
      tm_s2_q  <= tm_s1_q;
      v2_q     <= v1_q;
    end
  end

  fb_palette_ram #(
    .IDX_W  (IDX_W),
    .DATA_W (3 * COLOR_W)
  ) u_pal (
    .clk_i   (Clk),
    .we_i    (pal_we),
    .waddr_i (pal_waddr),
    .wdata_i (pal_wdata),
    .raddr_i (mem_rdata),
    .rdata_o (pal_rdata)
  );

  // Output stage: blank when not visible, bars bypass the palette in test mode
  always_ff @(posedge Clk) begin
    if (Reset || !v2_q) begin
      vga_r <= '0;
      vga_g <= '0;
      vga_b <= '0;
    end else if (tm_s2_q) begin
      vga_r <= {COLOR_W{bar_s2_q[2]}};
      vga_g <= {COLOR_W{bar_s2_q[1]}};
      vga_b <= {COLOR_W{bar_s2_q[0]}};
    end else begin
      vga_r <= pal_rdata[3*COLOR_W-1 -: COLOR_W];
      vga_g <= pal_rdata[2*COLOR_W-1 -: COLOR_W];
      vga_b <= pal_rdata[COLOR_W-1:0];
    end
  end

  // Swap FSM: flips only on frame_end; a request seen while ack is showing
  // is ignored so a requester dropping right after ack does not double-flip
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= IDLE;
      front_buf <= '0;
      swap_ack  <= 1'b0;
    end else begin
      swap_ack <= 1'b0;
      case (state_q)
        IDLE: begin
          if (swap_req && !swap_ack) begin
            if (frame_end) begin
              front_buf <= next_buf;
              swap_ack  <= 1'b1;
            end else begin
              state_q <= PEND;
            end
          end
        end
        PEND: begin
          if (frame_end) begin
            front_buf <= next_buf;
            swap_ack  <= 1'b1;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
